// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : RV32I load/store unit between a core request/response handshake
//             and a single-cycle-latency word memory. Handles byte/halfword
//             lane selection, store-data replication and load extension.
//  Option   : LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses
//             respond with rsp_err instead of being forced to alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [3:0]            mem_byte_sel,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_misalign;
    logic [ADDR_WIDTH-1:0] w_addr_eff;
    logic [31:0]           w_store_data;
    logic                  w_issue_ok;
    logic [3:0]            w_lanes;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load_data;

    // Decode the incoming request: legality, alignment handling, store data
    always_comb begin
        w_accept   = req_valid && (r_state == IDLE);
        // 011, 11x, and the unsigned codes used as stores have no meaning
        w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_funct3[2] && req_we);
        w_addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        // Without trapping, misaligned halfwords/words snap down to alignment
        w_misalign = 1'b0;
        if (req_funct3[1:0] == 2'b01)
            w_addr_eff[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            w_addr_eff[1:0] = 2'b00;
`endif
        case (req_funct3[1:0])
            2'b00:   w_store_data = {4{req_wdata[7:0]}};
            2'b01:   w_store_data = {2{req_wdata[15:0]}};
            default: w_store_data = req_wdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and handshake/memory-strobe outputs; strobes derive from the
    // asynchronously reset state so a reset in ISSUE kills them at once
    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_issue_ok   = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_byte_sel = 4'b0000;
        w_lanes      = 4'b1111;
        case (r_funct3[1:0])
            2'b00:   w_lanes = 4'b0001 << r_off;
            2'b01:   w_lanes = 4'b0011 << {r_off[1], 1'b0};
            default: w_lanes = 4'b1111;
        endcase
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = ISSUE;
            end
            ISSUE: begin
                w_issue_ok   = !r_err;
                mem_we       = w_issue_ok && r_we;
                mem_re       = w_issue_ok && !r_we;
                mem_byte_sel = w_issue_ok ? w_lanes : 4'b0000;
                w_next       = (r_err || r_we) ? RESP : CAPTURE;
            end
            CAPTURE: begin
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the accepted request; mem_addr/mem_wdata hold until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_off     <= 2'b00;
            r_err     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else if (w_accept) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_off     <= w_addr_eff[1:0];
            r_err     <= w_illegal || w_misalign;
            mem_addr  <= w_addr_eff[ADDR_WIDTH-1:2];
            mem_wdata <= w_store_data;
        end
    end

    // Align the returned word to the addressed lane and extend to 32 bits
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Response registers: cleared/flagged in ISSUE, load data filled in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (r_state == ISSUE) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= r_err;
        end else if (r_state == CAPTURE) begin
            rsp_rdata <= w_load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Table-driven self-checking bench for load_store_unit with a
//             behavioural word memory and a response scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [3:0]    mem_byte_sel;
    logic [31:0]   mem_rdata = 32'h0;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_byte_sel (mem_byte_sel),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: lane-masked writes, one-cycle read latency
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_byte_sel[b])
                    ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_re)
            mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [11:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_chk  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel, input logic [11:0] maddr,
                       input logic [31:0] mwdata, input logic [31:0] rdata, input logic err,
                       input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata; v.err = err; v.lat = lat;
        vt.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Wait for rsp_valid; returns cycles since the accept cycle
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   lat;
        n_vec++;
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        drive(v.we, v.f3, v.addr, v.wdata);
        e.rdata = v.rdata; e.err = v.err;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("issue_sel", {28'h0, mem_byte_sel}, {28'h0, v.sel});
        check("issue_we", {31'h0, mem_we}, {31'h0, (v.we && v.sel != 4'h0)});
        check("issue_re", {31'h0, mem_re}, {31'h0, (!v.we && v.sel != 4'h0)});
        if (!v.err)
            check("issue_addr", {20'h0, mem_addr}, {20'h0, v.maddr});
        if (v.we && !v.err)
            check("issue_wdata", mem_wdata, v.mwdata);
        wait_rsp(lat);
        check("latency", lat, v.lat);
        if (rsp_valid) begin
            check("resp_mem_idle", {26'h0, mem_we, mem_re, mem_byte_sel}, 32'h0);
            check("resp_req_ready", {31'h0, req_ready}, 32'h0);
            pop_cmp();
        end else begin
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        check("back_to_idle", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int lat;
        exp_t e;
        logic [31:0] held;

        //   we  f3      addr    wdata          sel   maddr  mwdata         rdata          err lat
        add(1, 3'b010, 14'h020, 32'h00000000, 4'hF, 12'd8, 32'h00000000, 32'h00000000, 0, 2);
        add(1, 3'b010, 14'h004, 32'hCAFEF00D, 4'hF, 12'd1, 32'hCAFEF00D, 32'h00000000, 0, 2);
        add(1, 3'b010, 14'h010, 32'hDEADBEEF, 4'hF, 12'd4, 32'hDEADBEEF, 32'h00000000, 0, 2);
        add(0, 3'b010, 14'h010, 32'h0,        4'hF, 12'd4, 32'h0,        32'hDEADBEEF, 0, 3);
        add(1, 3'b010, 14'h010, 32'h11223344, 4'hF, 12'd4, 32'h11223344, 32'h00000000, 0, 2);
        add(1, 3'b000, 14'h013, 32'h000000A5, 4'h8, 12'd4, 32'hA5A5A5A5, 32'h00000000, 0, 2);
        add(0, 3'b000, 14'h013, 32'h0,        4'h8, 12'd4, 32'h0,        32'hFFFFFFA5, 0, 3);
        add(0, 3'b100, 14'h013, 32'h0,        4'h8, 12'd4, 32'h0,        32'h000000A5, 0, 3);
        add(0, 3'b000, 14'h011, 32'h0,        4'h2, 12'd4, 32'h0,        32'h00000033, 0, 3);
        add(0, 3'b100, 14'h010, 32'h0,        4'h1, 12'd4, 32'h0,        32'h00000044, 0, 3);
        add(1, 3'b010, 14'h014, 32'h80017FFF, 4'hF, 12'd5, 32'h80017FFF, 32'h00000000, 0, 2);
        add(0, 3'b001, 14'h016, 32'h0,        4'hC, 12'd5, 32'h0,        32'hFFFF8001, 0, 3);
        add(0, 3'b101, 14'h016, 32'h0,        4'hC, 12'd5, 32'h0,        32'h00008001, 0, 3);
        add(0, 3'b001, 14'h014, 32'h0,        4'h3, 12'd5, 32'h0,        32'h00007FFF, 0, 3);
        add(1, 3'b001, 14'h016, 32'h1234BEEF, 4'hC, 12'd5, 32'hBEEFBEEF, 32'h00000000, 0, 2);
        add(0, 3'b010, 14'h014, 32'h0,        4'hF, 12'd5, 32'h0,        32'hBEEF7FFF, 0, 3);
        add(0, 3'b011, 14'h010, 32'h0,        4'h0, 12'd4, 32'h0,        32'h00000000, 1, 2);
        add(1, 3'b100, 14'h010, 32'hFFFFFFFF, 4'h0, 12'd4, 32'h0,        32'h00000000, 1, 2);
        add(0, 3'b110, 14'h010, 32'h0,        4'h0, 12'd4, 32'h0,        32'h00000000, 1, 2);
        add(1, 3'b111, 14'h010, 32'hFFFFFFFF, 4'h0, 12'd4, 32'h0,        32'h00000000, 1, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        add(0, 3'b010, 14'h006, 32'h0,        4'h0, 12'd1, 32'h0,        32'h00000000, 1, 2);
        add(0, 3'b001, 14'h013, 32'h0,        4'h0, 12'd4, 32'h0,        32'h00000000, 1, 2);
`else
        add(0, 3'b010, 14'h006, 32'h0,        4'hF, 12'd1, 32'h0,        32'hCAFEF00D, 0, 3);
        add(0, 3'b001, 14'h013, 32'h0,        4'hC, 12'd4, 32'h0,        32'hFFFFA522, 0, 3);
`endif

        // Values while reset is held
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_mem_ctl", {26'h0, mem_we, mem_re, mem_byte_sel}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) run_vec(vt[i]);

        // Back-pressure: hold the load response for 5 cycles
        n_vec++;
        rsp_ready = 1'b0;
        drive(1'b0, 3'b010, 14'h010, 32'h0);
        e.rdata = 32'hA5223344; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(lat);
        check("bp_latency", lat, 3);
        held = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid_held", {31'h0, rsp_valid}, 32'd1);
            check("bp_rdata_stable", rsp_rdata, held);
            check("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        pop_cmp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'h0, rsp_valid, req_ready}, 32'd1);

        // Reset pulse while a store is in ISSUE
        n_vec++;
        drive(1'b1, 3'b010, 14'h020, 32'h12345678);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_issue_reached", {31'h0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_abort_ctl", {26'h0, mem_we, mem_re, mem_byte_sel}, 32'h0);
        check("rst_abort_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("rst_abort_rdata", rsp_rdata, 32'h0);
        check("rst_abort_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_abort_wdata", mem_wdata, 32'h0);
        check("rst_abort_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("rst_no_resp", {31'h0, rsp_valid}, 32'h0);
        end
        check("rst_no_write", ram[8], 32'h0);

        // The unit resumes normally after the aborted access
        begin
            vec_t v;
            v.we = 0; v.f3 = 3'b010; v.addr = 14'h004; v.wdata = 0; v.sel = 4'hF;
            v.maddr = 12'd1; v.mwdata = 0; v.rdata = 32'hCAFEF00D; v.err = 0; v.lat = 3;
            run_vec(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the byte-address width; the memory word address is ADDR_WIDTH-2 bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port req_valid, input, 1: core request present.
REQ-006 Port req_ready, output, 1: unit can accept a request.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_funct3, input, 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Port req_addr, input, ADDR_WIDTH: byte address.
REQ-010 Port req_wdata, input, 32: store data, right-aligned.
REQ-011 Port rsp_valid, output, 1: response present.
REQ-012 Port rsp_ready, input, 1: core accepts the response.
REQ-013 Port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-014 Port rsp_err, output, 1: illegal funct3 or trapped misalignment.
REQ-015 Port mem_addr, output, ADDR_WIDTH-2: word address (req_addr[ADDR_WIDTH-1:2]).
REQ-016 Port mem_wdata, output, 32: lane-replicated store data.
REQ-017 Port mem_we, output, 1: memory write enable.
REQ-018 Port mem_re, output, 1: memory read enable.
REQ-019 Port mem_byte_sel, output, 4: byte-lane enables.
REQ-020 Port mem_rdata, input, 32: memory read data, valid one cycle after mem_re.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-022 IDLE: req_ready=1. On req_valid&req_ready, latch we/funct3/addr/wdata and go to ISSUE; req_ready=0 in all other states.
REQ-023 ISSUE: drive mem_* from the latched request for exactly one cycle. A store goes to RESP. A load goes to CAPTURE.
REQ-024 CAPTURE: sample mem_rdata, extract, extend, and register into rsp_rdata, then go to RESP.
REQ-025 RESP: hold rsp_valid=1 and stable data until rsp_ready, then go to IDLE; a new request SHALL NOT be accepted in the same cycle.
REQ-026 Latency from the accept edge to rsp_valid SHALL be 2 cycles for stores and 3 for loads.
REQ-027 mem_byte_sel SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111. Loads use the same lanes.
REQ-028 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-029 Load data SHALL be mem_rdata shifted right by 8*addr[1:0] and then masked to width; sign-extend for B/H, zero-extend for BU/HU. Unselected lanes SHALL be ignored.
REQ-030 Illegal funct3 (011, 110, 111, or 100/101 with req_we=1) SHALL give no mem_we/mem_re in ISSUE, go directly to RESP with rsp_err=1 and rsp_rdata=0.
REQ-031 mem_we, mem_re and mem_byte_sel SHALL be 0 outside ISSUE; mem_addr and mem_wdata hold their last values.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_re=0, mem_byte_sel=0, mem_addr=0 and mem_wdata=0; req_ready=1 while in reset.
REQ-033 Reset during ISSUE SHALL abort the access combinationally, and no response SHALL follow.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL issue no memory access and respond with rsp_err=1 and rsp_rdata=0.
REQ-035 LSU_MISALIGN_TRAP_EN undefined: the address SHALL be forced aligned (H clears bit 0, W clears bits 1:0), the access proceeds, and rsp_err covers illegal funct3 only.

Verification
REQ-036 SW addr 0x010, data 0xDEADBEEF -> at ISSUE: mem_addr=4, byte_sel=1111, we=1; rsp_valid at +2 with rsp_err=0.
REQ-037 SB addr 0x013, data 0x000000A5 -> byte_sel=1000, mem_wdata=0xA5A5A5A5; a following LB at 0x013 -> rsp_rdata=0xFFFFFFA5 at +3; LBU -> 0x000000A5.
REQ-038 LH addr 0x012 with word 0x8001_7FFF -> byte_sel=1100, rsp_rdata=0xFFFF8001; LHU -> 0x00008001.
REQ-039 LW addr 0x006: with LSU_MISALIGN_TRAP_EN, mem_re never asserts and rsp_err=1, rsp_rdata=0; without it, mem_addr=1 and the aligned word is returned.
REQ-040 Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; funct3=011 -> rsp_err=1; rst_n pulse in ISSUE -> no rsp_valid and all outputs at reset values.
